// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions.
package alu_pkg;

    localparam int WIDTH = 16;

    typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/half_adder.sv
// Single-bit half adder, the cell of the incrementer ripple chain.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/inc16.sv
// Registered incrementer: out = in + 1 mod 2^WIDTH, with carry-out and valid.
module inc16 #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    // Injecting a 1 at the chain's LSB turns the half-adder ripple into +1.
    assign c[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        half_adder u_ha (
            .a    (in[i]),
            .b    (c[i]),
            .sum  (sum[i]),
            .carry(c[i+1])
        );
    end

    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             valid_q, valid_d;

    always_comb begin
        out_d   = out_q;
        carry_d = carry_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d   = sum;
            carry_d = c[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign carry     = carry_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_inc16.sv
// Self-checking bench for inc16 against an arithmetic reference model.
module tb_inc16;
    import alu_pkg::*;

    logic  clk = 1'b0;
    logic  clk_en = 1'b0;
    logic  rst_n = 1'b1;
    logic  in_valid = 1'b0;
    word_t in = '0;
    logic  out_valid;
    word_t out;
    logic  carry;

    int checks = 0;
    int errors = 0;

    inc16 dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in       (in),
        .out_valid(out_valid),
        .out      (out),
        .carry    (carry)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic word_t ref_out(input word_t x);
        int unsigned s;
        s = (int'(x) + 1) % 65536;
        return word_t'(s);
    endfunction

    function automatic logic ref_carry(input word_t x);
        return (int'(x) + 1) >= 65536;
    endfunction

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000 || carry !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset out=%h carry=%b valid=%b need 0000/0/0",
                     out, carry, out_valid);
        end
        #2 rst_n = 1'b1;
        clk_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_directed();
        word_t vec [4];
        word_t eo  [4];
        logic  ec  [4];
        vec = '{16'h0000, 16'hFFFF, 16'h0005, 16'hFFFB};
        eo  = '{16'h0001, 16'h0000, 16'h0006, 16'hFFFC};
        ec  = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            in = vec[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out !== eo[i] || carry !== ec[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed in=%h out=%h carry=%b valid=%b need %h/%b/1",
                         vec[i], out, carry, out_valid, eo[i], ec[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        word_t vec [3];
        word_t eo  [3];
        vec = '{16'h00FF, 16'h7FFF, 16'h8000};
        eo  = '{16'h0100, 16'h8000, 16'h8001};
        for (int i = 0; i < 3; i++) begin
            in = vec[i];
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (out !== eo[i] || carry !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL b2b in=%h out=%h carry=%b valid=%b need %h/0/1",
                         vec[i], out, carry, out_valid, eo[i]);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_hold();
        in = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in = word_t'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (out !== 16'h0000 || carry !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL hold out=%h carry=%b valid=%b need 0000/1/0",
                         out, carry, out_valid);
            end
        end
    endtask

    task automatic test_mid_reset();
        in = 16'h1234;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in = 16'hFFFF;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000 || carry !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear out=%h carry=%b valid=%b need 0000/0/0",
                     out, carry, out_valid);
        end
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle out=%h valid=%b need 0000/0",
                     out, out_valid);
        end
        in = 16'h0041;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out !== 16'h0042 || carry !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_resume out=%h carry=%b valid=%b need 0042/0/1",
                     out, carry, out_valid);
        end
    endtask

    task automatic test_random();
        word_t exp_o;
        logic  exp_c;
        logic  exp_v;
        exp_o = out;
        exp_c = carry;
        for (int i = 0; i < 10000; i++) begin
            in_valid = ($urandom_range(0, 7) != 0);
            if (i % 97 == 0) in = 16'hFFFF;
            else in = word_t'($urandom);
            if (in_valid) begin
                exp_o = ref_out(in);
                exp_c = ref_carry(in);
            end
            exp_v = in_valid;
            @(posedge clk);
            #1;
            checks++;
            if (out !== exp_o || carry !== exp_c || out_valid !== exp_v) begin
                errors++;
                $display("FAIL random i=%0d out=%h carry=%b valid=%b need %h/%b/%b",
                         i, out, carry, out_valid, exp_o, exp_c, exp_v);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
